// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for a 16-bit ALU: reads operands from a small register file,
// drives registered ALU inputs, captures the ALU outputs and retires them.
module alu_issue_ctrl #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3,
  localparam int unsigned DW   = 16,
  localparam int unsigned OPW  = 5,
  localparam int unsigned SW   = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [AW-1:0]  in_rd,
  input  logic [AW-1:0]  in_rs1,
  input  logic [AW-1:0]  in_rs2,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [DW-1:0]  wr_data,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_f,
  output logic           alu_cin,
  input  logic [DW-1:0]  alu_result,
  input  logic [SW-1:0]  alu_status,
  output logic           done,
  output logic [DW-1:0]  done_result,
  output logic           err,
  output logic [SW-1:0]  flags
);

  localparam int unsigned CF_BIT = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0]     state_q,       state_d;
  logic           in_ready_q,    in_ready_d;
  logic [DW-1:0]  alu_a_q,       alu_a_d;
  logic [DW-1:0]  alu_b_q,       alu_b_d;
  logic [OPW-1:0] alu_f_q,       alu_f_d;
  logic           alu_cin_q,     alu_cin_d;
  logic [AW-1:0]  rd_q,          rd_d;
  logic           def_q,         def_d;
  logic [DW-1:0]  res_q,         res_d;
  logic [SW-1:0]  stat_q,        stat_d;
  logic           done_q,        done_d;
  logic [DW-1:0]  done_result_q, done_result_d;
  logic           err_q,         err_d;
  logic [SW-1:0]  flags_q,       flags_d;
  logic [DW-1:0]  rf_q [NREGS];
  logic [DW-1:0]  rf_d [NREGS];

  // Opcodes the ALU implements; anything else retires with err and no side effects.
  function automatic logic op_defined(input logic [OPW-1:0] op);
    logic def;
    casez (op)
      5'b00001, 5'b00011, 5'b001??, 5'b010??, 5'b10???: def = 1'b1;
      default:                                          def = 1'b0;
    endcase
    return def;
  endfunction

  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_f_d       = alu_f_q;
    alu_cin_d     = alu_cin_q;
    rd_d          = rd_q;
    def_d         = def_q;
    res_d         = res_q;
    stat_d        = stat_q;
    done_d        = 1'b0;
    done_result_d = done_result_q;
    err_d         = err_q;
    flags_d       = flags_q;
    rf_d          = rf_q;

    case (state_q)
      IDLE: begin
        // Operand reads use rf_q, so a same-cycle host write is not bypassed.
        if (wr_en) begin
          rf_d[wr_addr] = wr_data;
        end
        if (in_valid) begin
          alu_a_d    = rf_q[in_rs1];
          alu_b_d    = rf_q[in_rs2];
          alu_f_d    = in_op;
          alu_cin_d  = flags_q[CF_BIT];
          rd_d       = in_rd;
          def_d      = op_defined(in_op);
          in_ready_d = 1'b0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        stat_d  = alu_status;
        state_d = WB;
      end
      WB: begin
        if (def_q) begin
          rf_d[rd_q]    = res_q;
          flags_d       = stat_q;
          err_d         = 1'b0;
          done_result_d = res_q;
        end else begin
          err_d         = 1'b1;
          done_result_d = '0;
        end
        done_d     = 1'b1;
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b1;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_f_q       <= '0;
      alu_cin_q     <= 1'b0;
      rd_q          <= '0;
      def_q         <= 1'b0;
      res_q         <= '0;
      stat_q        <= '0;
      done_q        <= 1'b0;
      done_result_q <= '0;
      err_q         <= 1'b0;
      flags_q       <= '0;
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_f_q       <= alu_f_d;
      alu_cin_q     <= alu_cin_d;
      rd_q          <= rd_d;
      def_q         <= def_d;
      res_q         <= res_d;
      stat_q        <= stat_d;
      done_q        <= done_d;
      done_result_q <= done_result_d;
      err_q         <= err_d;
      flags_q       <= flags_d;
      rf_q          <= rf_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_f       = alu_f_q;
  assign alu_cin     = alu_cin_q;
  assign done        = done_q;
  assign done_result = done_result_q;
  assign err         = err_q;
  assign flags       = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU on the far side.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_f;
  logic        alu_cin;
  logic [15:0] alu_result;
  logic [5:0]  alu_status;
  logic        done;
  logic [15:0] done_result;
  logic        err;
  logic [5:0]  flags;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl #(.NREGS(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_status(alu_status),
    .done(done), .done_result(done_result), .err(err), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: ADD/ADC/SUB/SBB arithmetic, XOR for everything else.
  logic [16:0] m_wide;
  logic        m_c, m_cf, m_vf, m_af;
  always_comb begin
    m_wide = 17'd0;
    m_c    = 1'b0;
    m_cf   = 1'b0;
    m_vf   = 1'b0;
    m_af   = 1'b0;
    if (alu_f == 5'b00101 || alu_f == 5'b00111) m_c = alu_cin;
    case (alu_f)
      5'b00100, 5'b00101: begin
        m_wide = 17'(alu_a) + 17'(alu_b) + 17'(m_c);
        m_cf   = m_wide[16];
        m_af   = (5'(alu_a[3:0]) + 5'(alu_b[3:0]) + 5'(m_c)) > 5'd15;
        m_vf   = (alu_a[15] == alu_b[15]) && (m_wide[15] != alu_a[15]);
      end
      5'b00110, 5'b00111: begin
        m_wide = 17'(alu_a) - 17'(alu_b) - 17'(m_c);
        m_cf   = 17'(alu_a) < (17'(alu_b) + 17'(m_c));
        m_af   = 5'(alu_a[3:0]) < (5'(alu_b[3:0]) + 5'(m_c));
        m_vf   = (alu_a[15] != alu_b[15]) && (m_wide[15] != alu_a[15]);
      end
      default: m_wide = 17'(alu_a ^ alu_b);
    endcase
    alu_result = m_wide[15:0];
    alu_status = {m_cf, m_wide[15:0] == 16'd0, m_wide[15], m_vf, ~^m_wide[7:0], m_af};
  end

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] res;
    logic        err;
    logic [5:0]  fl;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                              input logic [2:0] rs2, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic [15:0] res, input logic e,
                              input logic [5:0] fl);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.a = a; v.b = b;
    v.cin = cin; v.res = res; v.err = e; v.fl = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] addr, input logic [15:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  // Issue from IDLE and follow it to the retire cycle (ends in IDLE with done high).
  task automatic run_instr(input vec_t v, input int idx);
    in_valid = 1'b1; in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    step();
    in_valid = 1'b0;
    check($sformatf("v%0d_exec_ready", idx), 32'(in_ready), 32'd0);
    check($sformatf("v%0d_alu_a", idx), 32'(alu_a), 32'(v.a));
    check($sformatf("v%0d_alu_b", idx), 32'(alu_b), 32'(v.b));
    check($sformatf("v%0d_alu_f", idx), 32'(alu_f), 32'(v.op));
    check($sformatf("v%0d_alu_cin", idx), 32'(alu_cin), 32'(v.cin));
    step();
    check($sformatf("v%0d_wb_done", idx), 32'(done), 32'd0);
    step();
    check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    check($sformatf("v%0d_result", idx), 32'(done_result), 32'(v.res));
    check($sformatf("v%0d_err", idx), 32'(err), 32'(v.err));
    check($sformatf("v%0d_flags", idx), 32'(flags), 32'(v.fl));
    check($sformatf("v%0d_ready", idx), 32'(in_ready), 32'd1);
  endtask

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(5'b00100, 3'd3, 3'd1, 3'd2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 6'b110011);
    vecs[1]  = mk(5'b00101, 3'd6, 3'd4, 3'd5, 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 6'b000000);
    vecs[2]  = mk(5'b00110, 3'd7, 3'd0, 3'd4, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 6'b101011);
    vecs[3]  = mk(5'b11111, 3'd3, 3'd7, 3'd6, 16'hFFFF, 16'h0004, 1'b1, 16'h0000, 1'b1, 6'b101011);
    vecs[4]  = mk(5'b11111, 3'd3, 3'd3, 3'd7, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 6'b101011);
    vecs[5]  = mk(5'b10000, 3'd0, 3'd6, 3'd7, 16'h0004, 16'hFFFF, 1'b1, 16'hFFFB, 1'b0, 6'b001000);
    vecs[6]  = mk(5'b00111, 3'd1, 3'd0, 3'd2, 16'hFFFB, 16'h0001, 1'b0, 16'hFFFA, 1'b0, 6'b001010);
    vecs[7]  = mk(5'b00100, 3'd2, 3'd1, 3'd1, 16'hFFFA, 16'hFFFA, 1'b0, 16'hFFF4, 1'b0, 6'b101001);
    vecs[8]  = mk(5'b00010, 3'd2, 3'd2, 3'd0, 16'hFFF4, 16'hFFFB, 1'b1, 16'h0000, 1'b1, 6'b101001);
    vecs[9]  = mk(5'b00001, 3'd5, 3'd2, 3'd3, 16'hFFF4, 16'h0000, 1'b1, 16'hFFF4, 1'b0, 6'b001000);
    vecs[10] = mk(5'b01100, 3'd5, 3'd5, 3'd4, 16'hFFF4, 16'h0001, 1'b0, 16'h0000, 1'b1, 6'b001000);
    vecs[11] = mk(5'b01011, 3'd4, 3'd5, 3'd4, 16'hFFF4, 16'h0001, 1'b0, 16'hFFF5, 1'b0, 6'b001010);
    vecs[12] = mk(5'b11000, 3'd4, 3'd4, 3'd4, 16'hFFF5, 16'hFFF5, 1'b0, 16'h0000, 1'b1, 6'b001010);

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step();
    step();
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_f", 32'(alu_f), 32'd0);
    check("rst_alu_cin", 32'(alu_cin), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_result", 32'(done_result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    host_write(3'd1, 16'hFFFF);
    host_write(3'd2, 16'h0001);
    host_write(3'd4, 16'h0001);
    host_write(3'd5, 16'h0002);

    for (int i = 0; i < 13; i++) begin
      run_instr(vecs[i], i);
    end

    // Back-to-back with in_valid held; host write during EXEC must be dropped.
    in_valid = 1'b1; in_op = 5'b11111; in_rd = 3'd0; in_rs1 = 3'd3; in_rs2 = 3'd0;
    step();
    check("b2b_exec_ready", 32'(in_ready), 32'd0);
    check("b2b_first_a", 32'(alu_a), 32'd0);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5A5;
    step();
    wr_en = 1'b0;
    check("b2b_wb_ready", 32'(in_ready), 32'd0);
    check("b2b_wb_done", 32'(done), 32'd0);
    step();
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_idle_ready", 32'(in_ready), 32'd1);
    step();
    check("b2b_second_accept", 32'(in_ready), 32'd0);
    check("b2b_done_pulse", 32'(done), 32'd0);
    check("b2b_exec_wr_dropped", 32'(alu_a), 32'd0);
    in_valid = 1'b0;
    step();
    step();
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_flags", 32'(flags), 32'(6'b001010));

    // Host write and accept in the same cycle: operand sees old value.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
    in_valid = 1'b1; in_op = 5'b11111; in_rs1 = 3'd3; in_rs2 = 3'd3;
    step();
    wr_en = 1'b0; in_valid = 1'b0;
    check("same_cycle_old_a", 32'(alu_a), 32'd0);
    step();
    step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("same_cycle_write_done", 32'(alu_a), 32'h1234);
    step();
    step();

    // Reset during EXEC abandons the instruction.
    in_valid = 1'b1; in_op = 5'b00100; in_rd = 3'd6; in_rs1 = 3'd3; in_rs2 = 3'd3;
    step();
    in_valid = 1'b0;
    check("mid_exec_f", 32'(alu_f), 32'(5'b00100));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("mid_rst_alu_b", 32'(alu_b), 32'd0);
    check("mid_rst_alu_f", 32'(alu_f), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("mid_rst_no_done%0d", i), 32'(done), 32'd0);
    end
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = 5'b11111; in_rs1 = 3'd6; in_rs2 = 3'd3;
    step();
    in_valid = 1'b0;
    check("mid_rst_rd_zero", 32'(alu_a), 32'd0);
    check("mid_rst_rf_cleared", 32'(alu_b), 32'd0);
    step();
    step();
    check("mid_rst_read_done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencer that sits directly upstream of the 16-bit ALU and also consumes its outputs.
- Accepts instructions over a valid/ready handshake and reads two operands from an internal register file.
- Drives the ALU operand, opcode and carry-in inputs from registers, then captures Result and Status.
- Writes the result back and keeps an architectural flags register whose CF feeds the next carry-in.
- A host write port preloads registers.

Parameters:
NREGS, 8, number of 16-bit general registers (power of 2)
AW, 3, register address width = log2(NREGS)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction valid
in_ready  out  1  instruction accepted when in_valid && in_ready
in_op  in  5  ALU opcode, forwarded to the ALU F input
in_rd  in  AW  destination register
in_rs1  in  AW  source register for operand A
in_rs2  in  AW  source register for operand B
wr_en  in  1  host register write
wr_addr  in  AW  host write address
wr_data  in  16  host write data
alu_a  out  16  to ALU A (registered)
alu_b  out  16  to ALU B (registered)
alu_f  out  5  to ALU F (registered)
alu_cin  out  1  to ALU Cin (registered)
alu_result  in  16  from ALU Result
alu_status  in  6  from ALU Status, ordered {CF,ZF,NF,VF,PF,AF}
done  out  1  one-cycle pulse, instruction retired
done_result  out  16  result of the retired instruction
err  out  1  valid with done; opcode undefined
flags  out  6  architectural flags register {CF,ZF,NF,VF,PF,AF}

Behaviour:
- Reset: async, active-low, takes effect immediately.
  - State = IDLE.
  - All register-file entries = 0; flags = 0.
  - alu_a, alu_b, alu_cin, done, done_result, err = 0.
  - alu_f = 5'b00000 (ALU default code).
  - in_ready = 1 after reset is released.
  - Reset mid-instruction abandons it: no writeback, no done.
- FSM states: IDLE, EXEC, WB. Each transition takes one cycle, so throughput is one instruction per 3 cycles.
- IDLE:
  - in_ready = 1.
  - On accept: alu_a <= rf[in_rs1], alu_b <= rf[in_rs2], alu_f <= in_op, alu_cin <= flags[5] (CF).
  - Latch in_rd and a defined-opcode bit, then go to EXEC.
- EXEC:
  - in_ready = 0; ALU inputs are held stable.
  - Sample alu_result/alu_status into internal capture registers, then go to WB.
- WB:
  - in_ready = 0.
  - If the opcode is defined: rf[rd] <= captured result, flags <= captured status, err <= 0.
  - If the opcode is undefined: no rf write, flags unchanged, err <= 1.
  - done <= 1 for exactly one cycle (the cycle after WB); done_result = captured result (0 for undefined).
  - Return to IDLE.
- Defined opcodes: 00001, 00011, 00100–00111, 01000–01011, 10000–10111. All other codes are undefined.
- alu_a, alu_b, alu_f and alu_cin hold their last values while in IDLE.
- Host write:
  - Honoured only in IDLE.
  - If wr_en and an instruction accept occur in the same cycle, the operand read sees the OLD contents (no bypass) and the host write still completes.
  - wr_en in EXEC or WB is dropped silently.
- Read-after-write: a writeback completes before the next accept, so no hazard logic is required.
- rd equal to rs1 or rs2 is legal.
- Register addresses wrap naturally within AW bits.

Test Plan:
- Reset, then host-write r1=0xFFFF and r2=0x0001, then ADD (00100) rd=r3 -> alu_a=0xFFFF, alu_b=0x0001, alu_f=00100 in EXEC; done 3 cycles after accept; r3=0x0000; flags=6'b110011.
- Immediately after, host-write r4=0x0001, r5=0x0002, then ADC (00101) rd=r6 -> alu_cin=1 (carry from the previous ADD); r6=0x0004; flags=6'b000000.
- r0=0x0000, r4=0x0001, SUB (00110) r7=r0-r4 -> r7=0xFFFF; flags=6'b101011.
- Opcode 5'b11111 with rd=r3 -> done=1, err=1, done_result=0; r3 and flags unchanged.
- in_valid held high across back-to-back instructions -> in_ready low in EXEC/WB; accepts exactly every 3 cycles; a wr_en pulse issued in EXEC has no effect on the register file.
- rst_n asserted during EXEC -> outputs go to reset values immediately; no done; target register reads 0 after reset.
